// File: rtl/mpc_sample_frontend_if.sv
// mpc_sample_frontend_if
//   Bundles the run/stop and busy handshake, the raw analog sample words and
//   the published sample set exchanged around the MPC sampling front end.
//   Ports (all inside the interface):
//     i_enable, i_busy          run/stop and MPC-busy handshake
//     i_Vpv, i_Ipv, i_Vout      raw Q16.16 samples
//     o_Vpv, o_Ipv, o_Vout      published (Ipv clamped) samples
//     o_delta_V, o_delta_I      saturated signed deltas, Q15.16
//     o_calc_DV, o_first        new-data strobe, no-history flag
//     o_spike, o_overrun        clamp flag, saturating drop count
//   Modports: master drives the inputs of the front end, slave is the front end.
interface mpc_sample_frontend_if #(
  parameter int WORD_SIZE = 32,
  parameter int OVR_W     = 8
);
  logic                 i_enable;
  logic                 i_busy;
  logic [WORD_SIZE-1:0] i_Vpv;
  logic [WORD_SIZE-1:0] i_Ipv;
  logic [WORD_SIZE-1:0] i_Vout;
  logic [WORD_SIZE-1:0] o_Vpv;
  logic [WORD_SIZE-1:0] o_Ipv;
  logic [WORD_SIZE-1:0] o_Vout;
  logic [WORD_SIZE-1:0] o_delta_V;
  logic [WORD_SIZE-1:0] o_delta_I;
  logic                 o_calc_DV;
  logic                 o_first;
  logic                 o_spike;
  logic [OVR_W-1:0]     o_overrun;

  modport master (
    output i_enable, i_busy, i_Vpv, i_Ipv, i_Vout,
    input  o_Vpv, o_Ipv, o_Vout, o_delta_V, o_delta_I,
    input  o_calc_DV, o_first, o_spike, o_overrun
  );

  modport slave (
    input  i_enable, i_busy, i_Vpv, i_Ipv, i_Vout,
    output o_Vpv, o_Ipv, o_Vout, o_delta_V, o_delta_I,
    output o_calc_DV, o_first, o_spike, o_overrun
  );
endinterface

// File: rtl/mpc_sample_frontend.sv
// mpc_sample_frontend
//   Upstream feeder for the MPC controller. Divides i_clk down to the control
//   sample period, captures Vpv/Ipv/Vout on each tick, clamps Ipv spikes,
//   forms saturated deltas against the previous accepted sample and publishes
//   the set with a one-cycle o_calc_DV strobe. Ticks that land while the MPC
//   reports busy are dropped and counted in a saturating overrun counter.
//   Ports:
//     i_clk    system clock (25 MHz nominal)
//     i_reset  asynchronous, active-high reset
//     bus      mpc_sample_frontend_if.slave (handshake, samples, results)
module mpc_sample_frontend #(
  parameter int WORD_SIZE     = 32,
  parameter int FRAC_BITS     = 16,
  parameter int SAMPLE_CYCLES = 375,
  parameter int IPV_LIMIT     = 10,
  parameter int IPV_SUB       = 1,
  parameter int OVR_W         = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  mpc_sample_frontend_if.slave bus
);

  localparam int INT_W = WORD_SIZE - FRAC_BITS;
  localparam int CNT_W = $clog2(SAMPLE_CYCLES);

  localparam logic [CNT_W-1:0]     CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]     CNT_LAST     = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [WORD_SIZE-1:0] WORD_ZERO    = {WORD_SIZE{1'b0}};
  localparam logic [INT_W-1:0]     IPV_LIMIT_L  = INT_W'(IPV_LIMIT);
  localparam logic [INT_W-1:0]     IPV_SUB_INT  = INT_W'(IPV_SUB);
  localparam logic [WORD_SIZE-1:0] IPV_SUB_WORD = {IPV_SUB_INT, {FRAC_BITS{1'b0}}};
  localparam logic [WORD_SIZE-1:0] SAT_POS      = {1'b0, {(WORD_SIZE-1){1'b1}}};
  localparam logic [WORD_SIZE-1:0] SAT_NEG      = {1'b1, {(WORD_SIZE-1){1'b0}}};
  localparam logic [OVR_W-1:0]     OVR_ZERO     = {OVR_W{1'b0}};
  localparam logic [OVR_W-1:0]     OVR_ONE      = OVR_W'(1);
  localparam logic [OVR_W-1:0]     OVR_MAX      = {OVR_W{1'b1}};

  // Difference of two unsigned words taken one bit wider, then saturated to
  // the signed word range. The top two bits of the wide result disagree only
  // when the true difference does not fit in a signed word.
  function automatic logic [WORD_SIZE-1:0] sat_delta(
    input logic [WORD_SIZE-1:0] cur,
    input logic [WORD_SIZE-1:0] prev
  );
    logic [WORD_SIZE:0] diff;
    diff = {1'b0, cur} - {1'b0, prev};
    case (diff[WORD_SIZE -: 2])
      2'b01:   return SAT_POS;
      2'b10:   return SAT_NEG;
      default: return diff[WORD_SIZE-1:0];
    endcase
  endfunction

  // Spike test on the integer part only; equality with the limit passes.
  function automatic logic ipv_is_spike(input logic [WORD_SIZE-1:0] ipv);
    return (ipv[WORD_SIZE-1:FRAC_BITS] > IPV_LIMIT_L);
  endfunction

  logic [CNT_W-1:0]     cnt_r;
  logic                 tick_s;
  logic                 take_s;
  logic                 drop_s;

  logic                 cap_valid_r;
  logic [WORD_SIZE-1:0] cap_vpv_r;
  logic [WORD_SIZE-1:0] cap_ipv_r;
  logic [WORD_SIZE-1:0] cap_vout_r;

  logic                 hist_valid_r;
  logic [WORD_SIZE-1:0] hist_vpv_r;
  logic [WORD_SIZE-1:0] hist_ipv_r;

  logic                 spike_s;
  logic [WORD_SIZE-1:0] ipv_clamped_s;
  logic [WORD_SIZE-1:0] delta_v_s;
  logic [WORD_SIZE-1:0] delta_i_s;

  logic [WORD_SIZE-1:0] o_vpv_r;
  logic [WORD_SIZE-1:0] o_ipv_r;
  logic [WORD_SIZE-1:0] o_vout_r;
  logic [WORD_SIZE-1:0] o_delta_v_r;
  logic [WORD_SIZE-1:0] o_delta_i_r;
  logic                 o_calc_dv_r;
  logic                 o_first_r;
  logic                 o_spike_r;
  logic [OVR_W-1:0]     o_overrun_r;

  // Enable gates the tick, so a tick in the cycle enable falls is ignored.
  assign tick_s = bus.i_enable & (cnt_r == CNT_LAST);
  // busy is only looked at in the tick cycle.
  assign take_s = tick_s & ~bus.i_busy;
  assign drop_s = tick_s &  bus.i_busy;

  // Sample-period divider: held at 0 while disabled, wraps after the last count.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_r <= CNT_ZERO;
    end else if (!bus.i_enable) begin
      cnt_r <= CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= CNT_ZERO;
    end else begin
      cnt_r <= cnt_r + CNT_ONE;
    end
  end

  // Capture stage: latch the raw inputs on an accepted tick and flag a publish.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cap_valid_r <= 1'b0;
      cap_vpv_r   <= WORD_ZERO;
      cap_ipv_r   <= WORD_ZERO;
      cap_vout_r  <= WORD_ZERO;
    end else begin
      cap_valid_r <= take_s;
      if (take_s) begin
        cap_vpv_r  <= bus.i_Vpv;
        cap_ipv_r  <= bus.i_Ipv;
        cap_vout_r <= bus.i_Vout;
      end else begin
        cap_vpv_r  <= cap_vpv_r;
        cap_ipv_r  <= cap_ipv_r;
        cap_vout_r <= cap_vout_r;
      end
    end
  end

  // Clamp and delta arithmetic on the captured set; deltas are 0 without history.
  always_comb begin
    spike_s       = ipv_is_spike(cap_ipv_r);
    ipv_clamped_s = cap_ipv_r;
    delta_v_s     = WORD_ZERO;
    delta_i_s     = WORD_ZERO;
    if (spike_s) begin
      ipv_clamped_s = IPV_SUB_WORD;
    end else begin
      ipv_clamped_s = cap_ipv_r;
    end
    if (hist_valid_r) begin
      delta_v_s = sat_delta(cap_vpv_r, hist_vpv_r);
      delta_i_s = sat_delta(ipv_clamped_s, hist_ipv_r);
    end else begin
      delta_v_s = WORD_ZERO;
      delta_i_s = WORD_ZERO;
    end
  end

  // Publish stage: register the result set, pulse the strobe, roll history.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_vpv_r      <= WORD_ZERO;
      o_ipv_r      <= WORD_ZERO;
      o_vout_r     <= WORD_ZERO;
      o_delta_v_r  <= WORD_ZERO;
      o_delta_i_r  <= WORD_ZERO;
      o_calc_dv_r  <= 1'b0;
      o_first_r    <= 1'b1;
      o_spike_r    <= 1'b0;
      hist_vpv_r   <= WORD_ZERO;
      hist_ipv_r   <= WORD_ZERO;
      hist_valid_r <= 1'b0;
    end else begin
      o_calc_dv_r <= cap_valid_r;
      if (cap_valid_r) begin
        o_vpv_r     <= cap_vpv_r;
        o_ipv_r     <= ipv_clamped_s;
        o_vout_r    <= cap_vout_r;
        o_delta_v_r <= delta_v_s;
        o_delta_i_r <= delta_i_s;
        o_first_r   <= ~hist_valid_r;
        o_spike_r   <= spike_s;
        hist_vpv_r  <= cap_vpv_r;
        hist_ipv_r  <= ipv_clamped_s;
      end else begin
        o_vpv_r     <= o_vpv_r;
        o_ipv_r     <= o_ipv_r;
        o_vout_r    <= o_vout_r;
        o_delta_v_r <= o_delta_v_r;
        o_delta_i_r <= o_delta_i_r;
        o_first_r   <= o_first_r;
        o_spike_r   <= o_spike_r;
        hist_vpv_r  <= hist_vpv_r;
        hist_ipv_r  <= hist_ipv_r;
      end
      // Disabling wins over an in-flight publish: that publish still goes out
      // with its own history, but the next one after re-enable starts fresh.
      if (!bus.i_enable) begin
        hist_valid_r <= 1'b0;
      end else if (cap_valid_r) begin
        hist_valid_r <= 1'b1;
      end else begin
        hist_valid_r <= hist_valid_r;
      end
    end
  end

  // Dropped-sample counter, saturating at all ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_overrun_r <= OVR_ZERO;
    end else if (drop_s && (o_overrun_r != OVR_MAX)) begin
      o_overrun_r <= o_overrun_r + OVR_ONE;
    end else begin
      o_overrun_r <= o_overrun_r;
    end
  end

  assign bus.o_Vpv     = o_vpv_r;
  assign bus.o_Ipv     = o_ipv_r;
  assign bus.o_Vout    = o_vout_r;
  assign bus.o_delta_V = o_delta_v_r;
  assign bus.o_delta_I = o_delta_i_r;
  assign bus.o_calc_DV = o_calc_dv_r;
  assign bus.o_first   = o_first_r;
  assign bus.o_spike   = o_spike_r;
  assign bus.o_overrun = o_overrun_r;

endmodule

// File: tb/tb_mpc_sample_frontend.sv
// tb_mpc_sample_frontend
//   Directed bench for mpc_sample_frontend. Instance A runs the nominal
//   375-cycle period; instance B uses a 4-cycle period so that overrun
//   saturation can be reached in a short run. Expected publishes are pushed
//   to a scoreboard queue when inputs are driven and popped at each strobe.
module tb_mpc_sample_frontend;

  typedef struct packed {
    logic [31:0] vpv;
    logic [31:0] ipv;
    logic [31:0] vout;
    logic [31:0] dv;
    logic [31:0] di;
    logic        first;
    logic        spike;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #20 clk = ~clk;

  mpc_sample_frontend_if ifa ();
  mpc_sample_frontend_if ifb ();

  mpc_sample_frontend #(.SAMPLE_CYCLES(375)) dut_a (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifa.slave)
  );

  mpc_sample_frontend #(.SAMPLE_CYCLES(4)) dut_b (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (ifb.slave)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        sb[$];
  bit          m_hv = 1'b0;
  logic [31:0] m_pv = 32'h0;
  logic [31:0] m_pi = 32'h0;
  int          m_ovr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] sat32(input longint d);
    if (d > 64'sd2147483647) return 32'h7FFF_FFFF;
    else if (d < -64'sd2147483648) return 32'h8000_0000;
    else return d[31:0];
  endfunction

  // Reference model of one accepted sample; updates the model history.
  task automatic push_exp(input logic [31:0] v, input logic [31:0] i, input logic [31:0] o);
    exp_t        e;
    logic [31:0] ic;
    e.spike = (i[31:16] > 16'd10);
    ic      = e.spike ? 32'h0001_0000 : i;
    e.vpv   = v;
    e.ipv   = ic;
    e.vout  = o;
    e.first = ~m_hv;
    if (m_hv) begin
      e.dv = sat32(longint'({32'h0, v}) - longint'({32'h0, m_pv}));
      e.di = sat32(longint'({32'h0, ic}) - longint'({32'h0, m_pi}));
    end else begin
      e.dv = 32'h0;
      e.di = 32'h0;
    end
    m_hv = 1'b1;
    m_pv = v;
    m_pi = ic;
    sb.push_back(e);
  endtask

  task automatic wait_strobe(input int budget, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    while (!got && n < budget) begin
      @(posedge clk);
      #1;
      n++;
      if (ifa.o_calc_DV === 1'b1) got = 1'b1;
    end
  endtask

  task automatic count_strobes(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      #1;
      if (ifa.o_calc_DV === 1'b1) cnt++;
    end
  endtask

  // Drive one sample, expect its publish, compare against the scoreboard.
  task automatic pub_step(input string tag, input logic [31:0] v, input logic [31:0] i,
                          input logic [31:0] o, input int gap);
    bit   got;
    int   n;
    exp_t e;
    ifa.i_Vpv  = v;
    ifa.i_Ipv  = i;
    ifa.i_Vout = o;
    push_exp(v, i, o);
    wait_strobe(2000, got, n);
    chk($sformatf("%s.strobe", tag), 32'(got), 32'd1);
    if (gap >= 0) chk($sformatf("%s.gap", tag), 32'(n), 32'(gap));
    e = sb.pop_front();
    if (got) begin
      chk($sformatf("%s.vpv", tag),   ifa.o_Vpv,            e.vpv);
      chk($sformatf("%s.ipv", tag),   ifa.o_Ipv,            e.ipv);
      chk($sformatf("%s.vout", tag),  ifa.o_Vout,           e.vout);
      chk($sformatf("%s.dv", tag),    ifa.o_delta_V,        e.dv);
      chk($sformatf("%s.di", tag),    ifa.o_delta_I,        e.di);
      chk($sformatf("%s.first", tag), 32'(ifa.o_first),     32'(e.first));
      chk($sformatf("%s.spike", tag), 32'(ifa.o_spike),     32'(e.spike));
      chk($sformatf("%s.ovr", tag),   32'(ifa.o_overrun),   32'(m_ovr));
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk($sformatf("%s.vpv", tag),   ifa.o_Vpv,          32'h0);
    chk($sformatf("%s.ipv", tag),   ifa.o_Ipv,          32'h0);
    chk($sformatf("%s.vout", tag),  ifa.o_Vout,         32'h0);
    chk($sformatf("%s.dv", tag),    ifa.o_delta_V,      32'h0);
    chk($sformatf("%s.di", tag),    ifa.o_delta_I,      32'h0);
    chk($sformatf("%s.calc", tag),  32'(ifa.o_calc_DV), 32'd0);
    chk($sformatf("%s.first", tag), 32'(ifa.o_first),   32'd1);
    chk($sformatf("%s.spike", tag), 32'(ifa.o_spike),   32'd0);
    chk($sformatf("%s.ovr", tag),   32'(ifa.o_overrun), 32'd0);
    chk($sformatf("%s.b_ovr", tag), 32'(ifb.o_overrun), 32'd0);
  endtask

  initial begin
    int cnt;
    ifa.i_enable = 1'b0; ifa.i_busy = 1'b0;
    ifa.i_Vpv = 32'h0; ifa.i_Ipv = 32'h0; ifa.i_Vout = 32'h0;
    ifb.i_enable = 1'b0; ifb.i_busy = 1'b0;
    ifb.i_Vpv = 32'h0; ifb.i_Ipv = 32'h0; ifb.i_Vout = 32'h0;

    // Reset state
    #1 rst = 1'b1;
    #2;
    chk_reset_state("rst0");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // First sample: 375-cycle period plus one cycle of latency
    ifa.i_enable = 1'b1;
    pub_step("s1", 32'h0014_0000, 32'h0002_0000, 32'h0030_0000, 376);
    // Second sample: deltas against the first
    pub_step("s2", 32'h0012_8000, 32'h0003_0000, 32'h0030_0000, 375);
    chk("s2.dv_const", ifa.o_delta_V, 32'hFFFE_8000);
    chk("s2.di_const", ifa.o_delta_I, 32'h0001_0000);
    chk("s2.first_const", 32'(ifa.o_first), 32'd0);

    // Strobe is one cycle wide and data holds when inputs move
    ifa.i_Vpv = 32'h1234_5678;
    @(posedge clk); #1;
    chk("hold.calc", 32'(ifa.o_calc_DV), 32'd0);
    chk("hold.vpv", ifa.o_Vpv, 32'h0012_8000);

    // Spike clamp and the strict boundary
    pub_step("s3", 32'h0012_8000, 32'h000B_4000, 32'h0030_0000, -1);
    chk("s3.ipv_const", ifa.o_Ipv, 32'h0001_0000);
    chk("s3.spike_const", 32'(ifa.o_spike), 32'd1);
    pub_step("s4", 32'h0012_8000, 32'h000A_0000, 32'h0030_0000, 375);
    chk("s4.ipv_const", ifa.o_Ipv, 32'h000A_0000);
    chk("s4.di_const", ifa.o_delta_I, 32'h0009_0000);

    // Busy across three ticks
    ifa.i_busy = 1'b1;
    count_strobes(1130, cnt);
    chk("busy.strobes", 32'(cnt), 32'd0);
    m_ovr = 3;
    chk("busy.ovr", 32'(ifa.o_overrun), 32'd3);
    ifa.i_busy = 1'b0;
    pub_step("s5", 32'h0010_0000, 32'h0002_0000, 32'h0031_0000, -1);
    chk("s5.dv_const", ifa.o_delta_V, 32'hFFFD_8000);

    // Delta saturation both ways
    pub_step("s6", 32'hFFFF_0000, 32'h0002_0000, 32'h0031_0000, 375);
    pub_step("s7", 32'h0000_0000, 32'h0002_0000, 32'h0031_0000, 375);
    chk("s7.sat_neg", ifa.o_delta_V, 32'h8000_0000);
    pub_step("s8", 32'hFFFF_0000, 32'h0002_0000, 32'h0031_0000, 375);
    chk("s8.sat_pos", ifa.o_delta_V, 32'h7FFF_FFFF);

    // Enable dropped for 100 clocks
    ifa.i_enable = 1'b0;
    m_hv = 1'b0;
    count_strobes(100, cnt);
    chk("dis.strobes", 32'(cnt), 32'd0);
    ifa.i_enable = 1'b1;
    pub_step("s9", 32'h0005_0000, 32'h0001_8000, 32'h0020_0000, 376);
    chk("s9.first_const", 32'(ifa.o_first), 32'd1);

    // Overrun saturation on the short-period instance
    ifa.i_enable = 1'b0;
    m_hv = 1'b0;
    ifb.i_busy = 1'b1;
    ifb.i_enable = 1'b1;
    repeat (402) @(posedge clk);
    #1;
    chk("b.ovr100", 32'(ifb.o_overrun), 32'd100);
    chk("b.calc", 32'(ifb.o_calc_DV), 32'd0);
    repeat (1000) @(posedge clk);
    #1;
    chk("b.ovr_sat", 32'(ifb.o_overrun), 32'd255);
    ifb.i_enable = 1'b0;

    // Reset asserted in the tick cycle
    ifa.i_enable = 1'b1;
    pub_step("s10", 32'h0007_0000, 32'h0004_0000, 32'h0022_0000, 376);
    repeat (373) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk_reset_state("rst1");
    #2 rst = 1'b0;
    m_hv = 1'b0;
    m_ovr = 0;
    count_strobes(370, cnt);
    chk("rst1.strobes", 32'(cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mpc_sample_frontend.md
Name: mpc_sample_frontend

Overview:
- Upstream feeder for the MPC controller stage.
- Divides the 25 MHz clock down to the 15 µs control sample period and captures Vpv, Ipv and Vout on each tick.
- Clamps current spikes, then computes signed deltas against the previous accepted sample.
- Publishes one coherent sample set to the MPC with a single-cycle calc strobe, and drops and counts samples that arrive while the MPC is still busy.

Parameters:
- WORD_SIZE, 32, width of every data word; unsigned Q16.16 on inputs.
- FRAC_BITS, 16, fractional bits of the fixed-point format.
- SAMPLE_CYCLES, 375, clocks per sample period (15 µs at 25 MHz); legal range is 2 or more.
- IPV_LIMIT, 10, integer-part threshold for the Ipv spike clamp.
- IPV_SUB, 1, integer value substituted for a clamped Ipv; the fraction is forced to 0.
- OVR_W, 8, width of the overrun counter.

Ports:
- i_clk  in  1  system clock, 25 MHz
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  run/stop for sampling
- i_busy  in  1  MPC is still computing the previous sample
- i_Vpv  in  WORD_SIZE  raw PV voltage, Q16.16
- i_Ipv  in  WORD_SIZE  raw PV current, Q16.16
- i_Vout  in  WORD_SIZE  raw converter output voltage, Q16.16
- o_Vpv  out  WORD_SIZE  published Vpv
- o_Ipv  out  WORD_SIZE  published Ipv, after the clamp
- o_Vout  out  WORD_SIZE  published Vout
- o_delta_V  out  WORD_SIZE  signed Vpv(k) − Vpv(k−1), Q15.16
- o_delta_I  out  WORD_SIZE  signed Ipv(k) − Ipv(k−1), Q15.16
- o_calc_DV  out  1  one-cycle strobe; the published data is new
- o_first  out  1  published sample has no history, so the deltas are 0
- o_spike  out  1  the clamp fired on the published sample
- o_overrun  out  OVR_W  saturating count of dropped samples

Behaviour:
- Reset (async assert, sync release):
  - All outputs go to 0; o_first=1.
  - Counter goes to 0; the history-valid flag is cleared.
- Counter:
  - Runs while i_enable=1 and counts 0..SAMPLE_CYCLES−1.
  - A tick fires in the cycle where count==SAMPLE_CYCLES−1; count then wraps to 0.
  - Result: exactly one tick per SAMPLE_CYCLES clocks.
- i_enable=0:
  - Counter is held at 0 and no ticks occur.
  - History-valid flag is cleared, so the next publish has o_first=1.
  - A capture already in flight still completes its publish.
  - On re-enable, the first tick arrives SAMPLE_CYCLES clocks later.
- Tick with i_busy=0, cycle T:
  - Raw inputs are latched into capture registers.
- Publish, cycle T+1:
  - Clamp: if captured Ipv[WORD_SIZE−1:FRAC_BITS] > IPV_LIMIT, Ipv := IPV_SUB<<FRAC_BITS and o_spike=1; otherwise o_spike=0. The comparison is strict, so exactly 10.0 passes unclamped.
  - Deltas: compute at WORD_SIZE+1 bits as current − previous accepted values (Ipv uses the clamped value), then saturate to the signed WORD_SIZE range (0x7FFFFFFF / 0x80000000).
  - If history is invalid, deltas are 0 and o_first=1; otherwise o_first=0.
  - Register all o_* data, pulse o_calc_DV=1 for exactly one cycle, update history with the current values and set history-valid.
  - Latency from tick to o_calc_DV is 1 clock.
- Hold: o_* data holds between strobes and changes only in the strobe cycle.
- Tick with i_busy=1:
  - The sample is dropped; no capture and no strobe.
  - History is unchanged.
  - o_overrun increments and saturates at 2^OVR_W−1.
  - The counter continues normally.
- i_busy is sampled only in the tick cycle; its value at other times is ignored.
- Reset mid-capture: any pending publish is cancelled and no strobe is emitted.
- Tick coinciding with the cycle i_enable falls: the tick is ignored because enable gates it.

Test Plan:
- Reset, then enable with Vpv=0x00140000, Ipv=0x00020000, Vout=0x00300000 and i_busy=0:
  - First o_calc_DV comes exactly 375 clocks after enable plus 1 clock of latency.
  - o_first=1, deltas are 0 and outputs match the inputs.
  - The next strobe follows exactly 375 clocks later.
- Second sample with Vpv=0x00128000, Ipv=0x00030000:
  - o_delta_V=0xFFFE8000 (−1.5).
  - o_delta_I=0x00010000 (+1.0).
  - o_first=0.
- Ipv=0x000B4000 (11.25):
  - o_Ipv=0x00010000 and o_spike=1.
  - The next delta_I is computed against 1.0.
  - Ipv=0x000A0000 (10.0) is not clamped.
- Hold i_busy=1 across 3 ticks:
  - No strobes; o_overrun=3.
  - The following accepted sample's deltas reference the last accepted sample.
  - Separately, force 300 overruns: o_overrun stays at 255.
- Saturation: previous Vpv=0xFFFF0000, current Vpv=0x00000000:
  - o_delta_V=0x80000000.
  - The reverse order gives 0x7FFFFFFF.
- Control events:
  - Drop i_enable for 100 clocks: no strobes; after re-enable the first strobe has o_first=1.
  - Assert i_reset in cycle T, the tick cycle: no strobe, and all outputs read 0 immediately, asynchronously.
